// File: rtl/calculate2.sv
// Six-operand arithmetic unit: sum, absolute half-difference, max and max-min range.
// Define CALCULATE2_PIPE_EN to add an input register stage (latency 2 instead of 1).
module calculate2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] N0,
  input  logic [5:0] N1,
  input  logic [5:0] N2,
  input  logic [5:0] N3,
  input  logic [5:0] N4,
  input  logic [5:0] N5,
  input  logic [1:0] MODE,
  output logic [9:0] OUT_N
);

  typedef enum logic [1:0] {
    OP_SUM     = 2'b00,
    OP_ABSDIFF = 2'b01,
    OP_MAX     = 2'b10,
    OP_RANGE   = 2'b11
  } op_e;

  logic [5:0] op_n [6];
  op_e        op_mode;

`ifdef CALCULATE2_PIPE_EN
  logic [5:0] n_q [6];
  op_e        mode_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 6; i++) n_q[i] <= '0;
      mode_q <= OP_SUM;
    end else begin
      n_q[0] <= N0;
      n_q[1] <= N1;
      n_q[2] <= N2;
      n_q[3] <= N3;
      n_q[4] <= N4;
      n_q[5] <= N5;
      mode_q <= op_e'(MODE);
    end
  end

  always_comb begin
    op_n    = n_q;
    op_mode = mode_q;
  end
`else
  always_comb begin
    op_n[0] = N0;
    op_n[1] = N1;
    op_n[2] = N2;
    op_n[3] = N3;
    op_n[4] = N4;
    op_n[5] = N5;
    op_mode = op_e'(MODE);
  end
`endif

  logic [7:0] sum_lo;
  logic [7:0] sum_hi;
  logic [8:0] sum_all;
  logic [7:0] abs_diff;
  logic [5:0] vmax;
  logic [5:0] vmin;
  logic [9:0] out_d;
  logic [9:0] out_q;

  always_comb begin
    // Partial sums are 8 bits wide so 3*63 fits; the full sum needs 9 bits for 378.
    sum_lo   = {2'b00, op_n[0]} + {2'b00, op_n[1]} + {2'b00, op_n[2]};
    sum_hi   = {2'b00, op_n[3]} + {2'b00, op_n[4]} + {2'b00, op_n[5]};
    sum_all  = {1'b0, sum_lo} + {1'b0, sum_hi};
    abs_diff = (sum_lo >= sum_hi) ? (sum_lo - sum_hi) : (sum_hi - sum_lo);
    vmax     = op_n[0];
    vmin     = op_n[0];
    for (int unsigned i = 1; i < 6; i++) begin
      if (op_n[i] > vmax) vmax = op_n[i];
      if (op_n[i] < vmin) vmin = op_n[i];
    end
    out_d = '0;
    unique case (op_mode)
      OP_SUM:     out_d = {1'b0, sum_all};
      OP_ABSDIFF: out_d = {2'b00, abs_diff};
      OP_MAX:     out_d = {4'b0000, vmax};
      OP_RANGE:   out_d = {4'b0000, 6'(vmax - vmin)};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) out_q <= '0;
    else     out_q <= out_d;
  end

  assign OUT_N = out_q;

endmodule

// File: tb/tb_calculate2.sv
// Self-checking bench for calculate2: per-cycle reference model plus directed literal checks.
// Works in both builds; latency follows CALCULATE2_PIPE_EN.
module tb_calculate2;

`ifdef CALCULATE2_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] n [6];
  logic [1:0] mode = 2'b00;
  logic [9:0] out_n;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  calculate2 dut (
    .clk  (clk),
    .rst  (rst),
    .N0   (n[0]),
    .N1   (n[1]),
    .N2   (n[2]),
    .N3   (n[3]),
    .N4   (n[4]),
    .N5   (n[5]),
    .MODE (mode),
    .OUT_N(out_n)
  );

  always #5 clk = ~clk;

  function automatic int model(input int a[6], input int m);
    int lo, hi, mx, mn;
    lo = a[0] + a[1] + a[2];
    hi = a[3] + a[4] + a[5];
    mx = a[0];
    mn = a[0];
    foreach (a[i]) begin
      if (a[i] > mx) mx = a[i];
      if (a[i] < mn) mn = a[i];
    end
    case (m)
      0:       return lo + hi;
      1:       return (lo > hi) ? lo - hi : hi - lo;
      2:       return mx;
      default: return mx - mn;
    endcase
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: OUT_N=%0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_n(input int a0, input int a1, input int a2,
                       input int a3, input int a4, input int a5, input int m);
    n[0] = 6'(a0); n[1] = 6'(a1); n[2] = 6'(a2);
    n[3] = 6'(a3); n[4] = 6'(a4); n[5] = 6'(a5);
    mode = 2'(m);
  endtask

  // Drive a vector, hold it for LAT edges, then compare against a hand-computed value.
  task automatic vec(input string name, input int a0, input int a1, input int a2,
                     input int a3, input int a4, input int a5, input int m, input int exp);
    @(negedge clk);
    set_n(a0, a1, a2, a3, a4, a5, m);
    repeat (LAT) @(negedge clk);
    chk(name, int'(out_n), exp);
  endtask

  // Per-cycle model: record reset and the model result of the inputs seen at each edge.
  bit rst_h[$];
  int res_h[$];

  initial begin : monitor
    int a[6];
    int t, exp;
    forever begin
      @(posedge clk);
      foreach (a[i]) a[i] = int'(n[i]);
      rst_h.push_back(rst);
      res_h.push_back(model(a, int'(mode)));
      #1;
      if (!done && rst_h.size() >= LAT) begin
        t = rst_h.size() - 1;
        if (rst_h[t])                    exp = 0;
        else if (LAT == 2 && rst_h[t-1]) exp = 0;
        else                             exp = res_h[t-LAT+1];
        chk("model", int'(out_n), exp);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int seq[4];
    seq[0] = 96; seq[1] = 74; seq[2] = 33; seq[3] = 33;
    set_n(33, 27, 25, 6, 5, 0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_state", int'(out_n), 0);
    rst = 1'b0;

    vec("sum",       33, 27, 25, 6, 5, 0, 0, 96);
    vec("absdiff",   33, 27, 25, 6, 5, 0, 1, 74);
    vec("max",       33, 27, 25, 6, 5, 0, 2, 33);
    vec("range",     33, 27, 25, 6, 5, 0, 3, 33);
    vec("sum_max",   63, 63, 63, 63, 63, 63, 0, 378);
    vec("range_eq",  63, 63, 63, 63, 63, 63, 3, 0);
    vec("max_eq",    63, 63, 63, 63, 63, 63, 2, 63);
    vec("diff_neg",  0, 0, 0, 63, 63, 63, 1, 189);
    vec("diff_pos",  63, 63, 63, 0, 0, 0, 1, 189);
    vec("sum_small", 1, 2, 3, 4, 5, 6, 0, 21);
    vec("diff_small",1, 2, 3, 4, 5, 6, 1, 9);
    vec("max_last",  1, 2, 3, 4, 5, 6, 2, 6);
    vec("range_sm",  1, 2, 3, 4, 5, 6, 3, 5);
    vec("zeros",     0, 0, 0, 0, 0, 0, 0, 0);

    // MODE stepped every cycle: check each result LAT edges after it was driven.
    for (int j = 0; j < 4 + LAT; j++) begin
      @(negedge clk);
      if (j >= LAT) chk($sformatf("mode_seq%0d", j - LAT), int'(out_n), seq[j-LAT]);
      if (j < 4) set_n(33, 27, 25, 6, 5, 0, j);
    end

    // One-cycle reset in the middle of a stream.
    vec("pre_rst", 33, 27, 25, 6, 5, 0, 0, 96);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst", int'(out_n), 0);
    rst = 1'b0;
    repeat (LAT) @(negedge clk);
    chk("post_rst", int'(out_n), 96);
    vec("post_rst_mode", 33, 27, 25, 6, 5, 0, 1, 74);

    repeat (2) @(negedge clk);
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calculate2.md
CALCULATE2 -- requirements
Module: calculate2

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 N0  input  6  unsigned operand 0.
REQ-005 N1  input  6  unsigned operand 1.
REQ-006 N2  input  6  unsigned operand 2.
REQ-007 N3  input  6  unsigned operand 3.
REQ-008 N4  input  6  unsigned operand 4.
REQ-009 N5  input  6  unsigned operand 5.
REQ-010 MODE  input  2  operation select.
REQ-011 OUT_N  output  10  registered unsigned result.
REQ-012 Port order SHALL be clk, rst, N0, N1, N2, N3, N4, N5, MODE, OUT_N.

Function
REQ-013 The block SHALL compute a result R from the current N0..N5 and MODE each cycle, with all operands treated as unsigned 0..63.
REQ-014 MODE=00: R SHALL be N0+N1+N2+N3+N4+N5, where the maximum is 378 and no overflow occurs.
REQ-015 MODE=01: R SHALL be |(N0+N1+N2) - (N3+N4+N5)|, in the range 0..189, computed without wrap.
REQ-016 MODE=10: R SHALL be max(N0..N5).
REQ-017 MODE=11: R SHALL be max(N0..N5) - min(N0..N5), in the range 0..63.
REQ-018 Results narrower than 10 bits SHALL be zero-extended onto OUT_N.
REQ-019 Without the pipeline option, OUT_N SHALL equal R of the inputs sampled at the previous rising edge (latency 1 cycle).
REQ-020 A MODE or operand change SHALL take effect at the first edge at which it is sampled, with no hold or debounce.
REQ-021 On equal operands, max and min SHALL return that shared value, so MODE=11 yields 0.
REQ-022 There is no handshake; the block SHALL accept a new operand set every cycle.

Reset
REQ-023 When rst=1 at a rising edge, OUT_N SHALL become 0 and every internal register SHALL clear to 0.
REQ-024 Reset SHALL have priority over computation, and an operation in flight SHALL be discarded.
REQ-025 On the first edge with rst=0, the block SHALL resume normal sampling, so the first valid OUT_N appears after the configured latency.

Configuration
REQ-026 Macro CALCULATE2_PIPE_EN: when defined, N0..N5 and MODE SHALL be captured in an input register stage before the compute stage, and the latency SHALL be 2 cycles.
REQ-027 When CALCULATE2_PIPE_EN is undefined, there SHALL be no input stage and the latency SHALL be 1 cycle.
REQ-028 The input stage SHALL also clear on rst.

Verification
REQ-029 N=(33,27,25,6,5,0), MODE=00 -> OUT_N=96 after the configured latency.
REQ-030 Same N, MODE=01 -> 74. Same N, MODE=10 -> 33. Same N, MODE=11 -> 33.
REQ-031 All N=63, MODE=00 -> 378. All N=63, MODE=11 -> 0.
REQ-032 N0..N2=0 and N3..N5=63, MODE=01 -> 189; the result must not wrap.
REQ-033 MODE cycled 00->01->10->11 on consecutive cycles with fixed N=(33,27,25,6,5,0) -> OUT_N sequence 96, 74, 33, 33, each offset by the configured latency.
REQ-034 rst asserted for 1 cycle mid-stream -> OUT_N=0 on the next edge, then correct results resume after the configured latency; run in both builds, with and without CALCULATE2_PIPE_EN.
